// File: rtl/behav_counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : behav_counter_sequencer
//  Description : Command-driven initiator for a behav_counter instance. It
//                shadows the expected count and checks qd after every command.
//  Revision    : 1.0  initial release
// ============================================================================
module behav_counter_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             ctr_clear,
    output logic             ctr_load,
    output logic [WIDTH-1:0] ctr_d,
    output logic             ctr_up_down,
    input  logic [WIDTH-1:0] ctr_qd,
    output logic             done,
    output logic [WIDTH-1:0] done_value,
    output logic             done_err,
    output logic             err_sticky
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_EXEC  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               err_sticky_q, err_sticky_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            exp_q        <= '0;
            steps_q      <= '0;
            op_q         <= OP_CLEAR;
            data_q       <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            steps_q      <= steps_d;
            op_q         <= op_d;
            data_q       <= data_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        steps_d      = steps_q;
        op_d         = op_q;
        data_d       = data_q;
        err_sticky_d = err_sticky_q;
        // Default drive parks the counter at the shadow value.
        cmd_ready    = 1'b0;
        ctr_clear    = 1'b0;
        ctr_load     = 1'b1;
        ctr_d        = exp_q;
        ctr_up_down  = 1'b1;
        done         = 1'b0;
        done_value   = '0;
        done_err     = 1'b0;

        case (state_q)
            S_INIT: begin
                ctr_clear = 1'b1;
                ctr_load  = 1'b0;
                exp_d     = '0;
                state_d   = S_IDLE;
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    steps_d = cmd_count;
                    if (cmd_op[1] && (cmd_count == '0)) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_CLEAR: begin
                        ctr_clear = 1'b1;
                        ctr_load  = 1'b0;
                        exp_d     = '0;
                        state_d   = S_CHECK;
                    end
                    OP_LOAD: begin
                        ctr_d   = data_q;
                        exp_d   = data_q;
                        state_d = S_CHECK;
                    end
                    default: begin
                        ctr_load    = 1'b0;
                        ctr_up_down = ~op_q[0];
                        exp_d       = op_q[0] ? (exp_q - 1'b1) : (exp_q + 1'b1);
                        steps_d     = steps_q - 1'b1;
                        if (steps_q == CNT_W'(1)) begin
                            state_d = S_CHECK;
                        end
                    end
                endcase
            end
            S_CHECK: begin
                done       = 1'b1;
                done_value = ctr_qd;
                done_err   = (ctr_qd != exp_q);
                if (ctr_qd != exp_q) begin
                    err_sticky_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign err_sticky = err_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_behav_counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_behav_counter_sequencer
//  Description : Bench for behav_counter_sequencer with a behavioural counter
//                and an arithmetic model of the expected count.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_behav_counter_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             ctr_clear;
    logic             ctr_load;
    logic [WIDTH-1:0] ctr_d;
    logic             ctr_up_down;
    logic [WIDTH-1:0] ctr_qd;
    logic             done;
    logic [WIDTH-1:0] done_value;
    logic             done_err;
    logic             err_sticky;

    logic             fault = 1'b0;
    logic [7:0]       model_v;
    logic             sticky_exp;
    int               n_pass = 0;
    int               n_total = 0;

    always #5 clk = ~clk;

    behav_counter_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_count   (cmd_count),
        .ctr_clear   (ctr_clear),
        .ctr_load    (ctr_load),
        .ctr_d       (ctr_d),
        .ctr_up_down (ctr_up_down),
        .ctr_qd      (ctr_qd),
        .done        (done),
        .done_value  (done_value),
        .done_err    (done_err),
        .err_sticky  (err_sticky)
    );

    // Counter under control; fault forces qd stuck at zero.
    always @(posedge clk) begin
        if (fault)            ctr_qd <= '0;
        else if (ctr_clear)   ctr_qd <= '0;
        else if (ctr_load)    ctr_qd <= ctr_d;
        else if (ctr_up_down) ctr_qd <= ctr_qd + 1'b1;
        else                  ctr_qd <= ctr_qd - 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic apply_reset(input int cyc);
        rst_n = 1'b0;
        repeat (cyc) tick();
        check("rst_outputs", 32'({done, done_err, done_value, cmd_ready, err_sticky}), 32'(0));
        rst_n      = 1'b1;
        model_v    = 8'h00;
        sticky_exp = 1'b0;
        check("init_clear", 32'({ctr_clear, ctr_load, cmd_ready, done}), 32'(4'b1000));
        tick();
        check("idle_hold", 32'({cmd_ready, ctr_load, ctr_clear, ctr_d, done}),
              32'({3'b110, 8'h00, 1'b0}));
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, input logic [7:0] cnt);
        int         n;
        int         lat;
        int         w;
        logic [7:0] expv;
        w = 0;
        while (!cmd_ready && w < 10) begin
            tick();
            w++;
        end
        check("ready_before_cmd", 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = cnt;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 8'($urandom);
        cmd_count = 8'($urandom);
        case (op)
            2'b00:   model_v = 8'h00;
            2'b01:   model_v = data;
            2'b10:   model_v = model_v + cnt;
            default: model_v = model_v - cnt;
        endcase
        n   = op[1] ? int'(cnt) : 1;
        lat = 1;
        while (!done && lat <= n + 3) begin
            if (op == 2'b01)
                check("load_drive", 32'({ctr_load, ctr_d}), 32'({1'b1, data}));
            else if (op == 2'b00)
                check("clear_drive", 32'({ctr_clear, ctr_load}), 32'(2'b10));
            else
                check("count_drive", 32'({ctr_clear, ctr_load, ctr_up_down}), 32'({2'b00, ~op[0]}));
            tick();
            lat++;
        end
        check("done_latency", 32'(lat), 32'(n + 1));
        expv = fault ? 8'h00 : model_v;
        check("done_value", 32'(done_value), 32'(expv));
        check("done_err", 32'(done_err), 32'(expv != model_v));
        if (expv != model_v) sticky_exp = 1'b1;
        check("ready_in_check", 32'(cmd_ready), 32'(0));
        tick();
        check("err_sticky", 32'(err_sticky), 32'(sticky_exp));
        check("ready_after", 32'({cmd_ready, done}), 32'(2'b10));
        check("hold_drive", 32'({ctr_load, ctr_d}), 32'({1'b1, model_v}));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_data   = '0;
        cmd_count  = '0;
        model_v    = 8'h00;
        sticky_exp = 1'b0;
        apply_reset(3);

        do_cmd(2'b01, 8'h5A, 8'd0);
        do_cmd(2'b01, 8'hFD, 8'd0);
        do_cmd(2'b10, 8'h00, 8'd5);
        do_cmd(2'b01, 8'h01, 8'd0);
        do_cmd(2'b11, 8'h00, 8'd3);
        do_cmd(2'b10, 8'h00, 8'd0);
        do_cmd(2'b00, 8'h00, 8'd0);

        fault = 1'b1;
        do_cmd(2'b01, 8'h33, 8'd0);
        do_cmd(2'b00, 8'h00, 8'd0);
        fault = 1'b0;
        tick();

        // Abandon a COUNT_UP 10 in its third step.
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_count = 8'd10;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midcmd_reset", 32'({done, cmd_ready}), 32'(0));
        apply_reset(2);
        do_cmd(2'b10, 8'h00, 8'd2);

        for (int i = 0; i < 25; i++) begin
            logic [1:0] rop;
            logic [7:0] rcnt;
            rop  = 2'($urandom_range(0, 3));
            rcnt = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            repeat ($urandom_range(0, 3)) tick();
            do_cmd(rop, 8'($urandom), rcnt);
        end
        do_cmd(2'b10, 8'h00, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
